store_queue: RTL and testbench
==============================

# store_queue

Parametrised, in-order store queue for the out-of-order OTTER core; successor to the single-entry store execution unit. Buffers up to DEPTH dispatched stores, snoops the common data bus (CDB) for pending base/data operands, and drains the oldest ready store to data memory through a hold-until-ack write handshake. Each completion is reported back to the reservation-station/ROB logic with the store's tag. Sits between dispatch and the memory port-2 interface.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, data/address width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- disp_valid  in  1  dispatch a store this cycle
- disp_ready  out  1  queue not full; registered; equals count != DEPTH
- disp_V1 / disp_V2 / disp_V3  in  XLEN  base / offset (already sign-extended) / store data
- disp_V1_valid / disp_V3_valid  in  1  base / data operand already available
- disp_V1_tag / disp_V3_tag  in  RS_tag_type  producer tag when the operand is not valid
- disp_rd_tag  in  RS_tag_type  the store's own tag
- disp_mem_type  in  3  [2]=sign, [1:0]=size
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  RS_tag_type  CDB producer tag
- cdb_value  in  XLEN  CDB result
- flush  in  1  squash all non-issued entries
- MEM_WRITE  out  1  write request; held until acknowledged
- MEM_ADDR2  out  XLEN  V1+V2 of the head entry
- MEM_DIN2  out  XLEN  V3 of the head entry
- MEM_SIZE  out  2  mem_type[1:0]
- MEM_SIGN  out  1  mem_type[2]
- mem_resp_valid  in  1  one-cycle acknowledge of the outstanding write
- done  out  1  one-cycle pulse: store retired to memory
- done_tag  out  RS_tag_type  rd_tag of the retired store
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer: head and tail pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately.
- Dispatch:
  - Fires when disp_valid && disp_ready; the entry is written at tail and tail increments.
  - Operand bypass: if cdb_valid and cdb_tag matches a not-valid operand tag in the same cycle, capture cdb_value and mark the operand valid.
- Snoop: every cycle, each occupied entry with a not-valid V1 or V3 whose tag equals cdb_tag (while cdb_valid) captures cdb_value and marks that operand valid. Both operands may capture in one cycle.
- Issue FSM, with states IDLE and WAIT:
  - IDLE→WAIT when count>0 and head V1 and V3 are both valid. MEM_WRITE asserts in the cycle after the transition. Address/data/size/sign are registered at the transition and held stable throughout WAIT.
  - WAIT→IDLE on mem_resp_valid. In that cycle done=1 and done_tag=head rd_tag; at the edge head increments and count decrements.
  - mem_resp_valid in IDLE is ignored.
- Stores retire strictly in program order. A younger ready entry never bypasses an unready head.
- Address is computed as MEM_ADDR2 = V1+V2, modulo 2^XLEN. There is no alignment check.
- Flush:
  - Clears every entry not in WAIT and sets tail = head, or tail = head+1 if in WAIT. count is set to 0 or 1 accordingly.
  - An in-flight (WAIT) store completes normally.
  - Dispatch in the flush cycle is dropped.
- Simultaneous dispatch and retire: count is unchanged and both pointers advance. Because disp_ready is computed from the registered count, a full queue does not accept a dispatch even in a retiring cycle.

## Timing
- Reset (async, RST_N=0) clears all of the following:
  - head, tail, count all 0
  - all valid bits 0
  - FSM in IDLE
  - MEM_WRITE, done all 0
  - done_tag, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN all 0
  - disp_ready=1
- Reset mid-WAIT abandons the request: MEM_WRITE drops immediately.
- Latency from dispatch with both operands valid into an empty queue: the entry is written at edge 0, IDLE→WAIT at edge 1, and MEM_WRITE is high from cycle 2.
- With a single-cycle memory ack, the minimum is one store retired per 2 cycles.
- CDB capture is visible to the issue decision on the cycle after the broadcast.
- done is registered-free: it is combinational from mem_resp_valid in WAIT.

## Structure
- The shared package (otter_pkg) holds:
  - RS_tag_type
  - the mem_type size encodings (BYTE=2'b00, HALF=2'b01, WORD=2'b10)
  - sq_entry_t struct: busy, V1, V2, V3, V1_valid, V3_valid, V1_tag, V3_tag, rd_tag, mem_type
  - sq_state_t enum {IDLE, WAIT}
- Single module; no sub-module is needed. The entry array is a register array, not RAM, because the snoop compares all entries in parallel.

## Test plan
- Ready store: dispatch V1=0x100, V2=0x8, V3=0xDEADBEEF, mem_type=3'b010 → MEM_WRITE in cycle 2 with ADDR2=0x108, DIN2=0xDEADBEEF, SIZE=2; ack in cycle 4 → done with done_tag = disp_rd_tag; count returns to 0.
- CDB wakeup: dispatch with V3 invalid (tag 5); broadcast tag 5 value 0x55 three cycles later → MEM_WRITE the next cycle with DIN2=0x55; a broadcast on tag 6 causes no capture.
- Ordering: dispatch A (base pending) then B (ready) → no write until A's base arrives; retire order is A then B.
- Full and wrap: fill DEPTH=4 → disp_ready=0 and a fifth dispatch is ignored; retire and refill 6 stores total → addresses emitted in order across pointer wrap.
- Flush: 3 entries, head in WAIT, assert flush → count=1; ack → done for the head only; nothing further issued.
- Async reset while MEM_WRITE=1 → all outputs 0 without waiting for a clock edge; a later mem_resp_valid produces no done.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER types: reservation-station tags, memory access encodings and
// the store-queue entry/state definitions.
package otter_pkg;

  localparam int OTTER_XLEN = 32;
  localparam int RS_TAG_W   = 5;

  typedef logic [RS_TAG_W-1:0] RS_tag_type;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef struct packed {
    logic                  busy;
    logic [OTTER_XLEN-1:0] V1;
    logic [OTTER_XLEN-1:0] V2;
    logic [OTTER_XLEN-1:0] V3;
    logic                  V1_valid;
    logic                  V3_valid;
    RS_tag_type            V1_tag;
    RS_tag_type            V3_tag;
    RS_tag_type            rd_tag;
    logic [2:0]            mem_type;
  } sq_entry_t;

  typedef enum logic {IDLE, WAIT} sq_state_t;

endpackage

// File: rtl/store_queue.sv
// In-order store queue: buffers dispatched stores, snoops the CDB for pending
// base/data operands and drains the oldest ready store through a hold-until-ack port.
module store_queue
  import otter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = OTTER_XLEN
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [XLEN-1:0]            disp_V1,
  input  logic [XLEN-1:0]            disp_V2,
  input  logic [XLEN-1:0]            disp_V3,
  input  logic                       disp_V1_valid,
  input  logic                       disp_V3_valid,
  input  RS_tag_type                 disp_V1_tag,
  input  RS_tag_type                 disp_V3_tag,
  input  RS_tag_type                 disp_rd_tag,
  input  logic [2:0]                 disp_mem_type,
  input  logic                       cdb_valid,
  input  RS_tag_type                 cdb_tag,
  input  logic [XLEN-1:0]            cdb_value,
  input  logic                       flush,
  output logic                       MEM_WRITE,
  output logic [XLEN-1:0]            MEM_ADDR2,
  output logic [XLEN-1:0]            MEM_DIN2,
  output logic [1:0]                 MEM_SIZE,
  output logic                       MEM_SIGN,
  input  logic                       mem_resp_valid,
  output logic                       done,
  output RS_tag_type                 done_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  sq_entry_t       ent_q [DEPTH];
  sq_entry_t       ent_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  sq_state_t       state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, din_q, din_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;

  sq_entry_t head_e, new_e;
  logic      head_rdy, disp_fire, retire, keep_head;

  assign disp_ready = (count_q != CW'(DEPTH));
  assign MEM_WRITE  = (state_q == WAIT);
  assign MEM_ADDR2  = addr_q;
  assign MEM_DIN2   = din_q;
  assign MEM_SIZE   = size_q;
  assign MEM_SIGN   = sign_q;
  assign count      = count_q;

  assign head_e    = ent_q[head_q];
  assign head_rdy  = (count_q != '0) && head_e.V1_valid && head_e.V3_valid;
  assign disp_fire = disp_valid && disp_ready && !flush;
  assign retire    = (state_q == WAIT) && mem_resp_valid;
  assign keep_head = (state_q == WAIT) && !retire;

  assign done     = retire;
  assign done_tag = retire ? head_e.rd_tag : '0;

  // Incoming entry, with same-cycle CDB bypass for pending operands.
  always_comb begin
    new_e          = '0;
    new_e.busy     = 1'b1;
    new_e.V1       = disp_V1;
    new_e.V2       = disp_V2;
    new_e.V3       = disp_V3;
    new_e.V1_valid = disp_V1_valid;
    new_e.V3_valid = disp_V3_valid;
    new_e.V1_tag   = disp_V1_tag;
    new_e.V3_tag   = disp_V3_tag;
    new_e.rd_tag   = disp_rd_tag;
    new_e.mem_type = disp_mem_type;
    if (cdb_valid && !disp_V1_valid && (cdb_tag == disp_V1_tag)) begin
      new_e.V1       = cdb_value;
      new_e.V1_valid = 1'b1;
    end
    if (cdb_valid && !disp_V3_valid && (cdb_tag == disp_V3_tag)) begin
      new_e.V3       = cdb_value;
      new_e.V3_valid = 1'b1;
    end
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    size_d  = size_q;
    sign_d  = sign_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy && cdb_valid) begin
        if (!ent_q[i].V1_valid && (ent_q[i].V1_tag == cdb_tag)) begin
          ent_d[i].V1       = cdb_value;
          ent_d[i].V1_valid = 1'b1;
        end
        if (!ent_q[i].V3_valid && (ent_q[i].V3_tag == cdb_tag)) begin
          ent_d[i].V3       = cdb_value;
          ent_d[i].V3_valid = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        // A flush squashes the head before it can issue.
        if (head_rdy && !flush) begin
          state_d = WAIT;
          addr_d  = head_e.V1 + head_e.V2;
          din_d   = head_e.V3;
          size_d  = head_e.mem_type[1:0];
          sign_d  = head_e.mem_type[2];
        end
      end
      WAIT: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      ent_d[head_q] = '0;
      head_d        = head_q + 1'b1;
    end

    if (disp_fire) begin
      ent_d[tail_q] = new_e;
      tail_d        = tail_q + 1'b1;
    end

    count_d = count_q + CW'(disp_fire) - CW'(retire);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(keep_head && (PW'(i) == head_q))) ent_d[i] = '0;
      end
      tail_d  = keep_head ? head_q + 1'b1 : head_d;
      count_d = keep_head ? CW'(1) : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: latency, CDB wakeup, ordering, full/wrap,
// flush with an in-flight head, and async reset mid-request.
module tb_store_queue;
  import otter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        disp_valid, disp_ready;
  logic [31:0] disp_V1, disp_V2, disp_V3;
  logic        disp_V1_valid, disp_V3_valid;
  RS_tag_type  disp_V1_tag, disp_V3_tag, disp_rd_tag;
  logic [2:0]  disp_mem_type;
  logic        cdb_valid;
  RS_tag_type  cdb_tag;
  logic [31:0] cdb_value;
  logic        flush;
  logic        MEM_WRITE;
  logic [31:0] MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic        mem_resp_valid;
  logic        done;
  RS_tag_type  done_tag;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  store_queue #(.DEPTH(4), .XLEN(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_V1(disp_V1), .disp_V2(disp_V2), .disp_V3(disp_V3),
    .disp_V1_valid(disp_V1_valid), .disp_V3_valid(disp_V3_valid),
    .disp_V1_tag(disp_V1_tag), .disp_V3_tag(disp_V3_tag),
    .disp_rd_tag(disp_rd_tag), .disp_mem_type(disp_mem_type),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush),
    .MEM_WRITE(MEM_WRITE), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .mem_resp_valid(mem_resp_valid),
    .done(done), .done_tag(done_tag), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
                      input logic v1v, input logic v3v, input RS_tag_type t1,
                      input RS_tag_type t3, input RS_tag_type rd, input logic [2:0] mt);
    disp_valid = 1'b1; disp_V1 = v1; disp_V2 = v2; disp_V3 = v3;
    disp_V1_valid = v1v; disp_V3_valid = v3v;
    disp_V1_tag = t1; disp_V3_tag = t3; disp_rd_tag = rd; disp_mem_type = mt;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    #2;
    checks++; if (MEM_WRITE !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_ctl: MEM_WRITE=%b done=%b, want 0 0", MEM_WRITE, done); end
    checks++; if (MEM_ADDR2 !== 32'h0 || MEM_DIN2 !== 32'h0 || MEM_SIZE !== 2'b0 || MEM_SIGN !== 1'b0) begin errors++;
      $display("FAIL reset_data: addr=%h din=%h size=%b sign=%b, want zeros", MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN); end
    checks++; if (count !== 3'd0 || disp_ready !== 1'b1 || done_tag !== 5'd0) begin errors++;
      $display("FAIL reset_cnt: count=%0d ready=%b done_tag=%0d, want 0 1 0", count, disp_ready, done_tag); end
    step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_ready_store;
    disp(32'h100, 32'h8, 32'hDEADBEEF, 1, 1, 0, 0, 5'd9, 3'b010);
    checks++; if (count !== 3'd1 || MEM_WRITE !== 1'b0) begin errors++;
      $display("FAIL ready_c1: count=%0d write=%b, want 1 0", count, MEM_WRITE); end
    step();
    checks++; if (MEM_WRITE !== 1'b1 || MEM_ADDR2 !== 32'h108 || MEM_DIN2 !== 32'hDEADBEEF || MEM_SIZE !== 2'd2 || MEM_SIGN !== 1'b0) begin errors++;
      $display("FAIL ready_c2: write=%b addr=%h din=%h size=%0d sign=%b, want 1 108 deadbeef 2 0", MEM_WRITE, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN); end
    step();
    checks++; if (MEM_WRITE !== 1'b1 || MEM_ADDR2 !== 32'h108 || done !== 1'b0) begin errors++;
      $display("FAIL ready_hold: write=%b addr=%h done=%b, want 1 108 0", MEM_WRITE, MEM_ADDR2, done); end
    step();
    mem_resp_valid = 1'b1;
    #1;
    checks++; if (done !== 1'b1 || done_tag !== 5'd9) begin errors++;
      $display("FAIL ready_done: done=%b tag=%0d, want 1 9", done, done_tag); end
    step();
    mem_resp_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || MEM_WRITE !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL ready_after: count=%0d write=%b done=%b, want 0 0 0", count, MEM_WRITE, done); end
  endtask

  task automatic test_cdb_wakeup;
    disp(32'h40, 32'h4, 32'h0, 1, 0, 0, 5'd5, 5'd2, 3'b010);
    step();
    cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'h66;
    step();
    cdb_valid = 1'b0;
    checks++; if (MEM_WRITE !== 1'b0) begin errors++;
      $display("FAIL cdb_wrongtag: write=%b, want 0", MEM_WRITE); end
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'h55;
    step();
    cdb_valid = 1'b0;
    checks++; if (MEM_WRITE !== 1'b0) begin errors++;
      $display("FAIL cdb_early: write=%b, want 0", MEM_WRITE); end
    step();
    checks++; if (MEM_WRITE !== 1'b1 || MEM_DIN2 !== 32'h55 || MEM_ADDR2 !== 32'h44) begin errors++;
      $display("FAIL cdb_write: write=%b din=%h addr=%h, want 1 55 44", MEM_WRITE, MEM_DIN2, MEM_ADDR2); end
    mem_resp_valid = 1'b1;
    #1;
    checks++; if (done !== 1'b1 || done_tag !== 5'd2) begin errors++;
      $display("FAIL cdb_done: done=%b tag=%0d, want 1 2", done, done_tag); end
    step();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_ordering;
    int n;
    disp(32'h0, 32'h10, 32'hA, 0, 1, 5'd7, 0, 5'd3, 3'b010);
    disp(32'h200, 32'h4, 32'hB, 1, 1, 0, 0, 5'd4, 3'b010);
    step(); step(); step();
    checks++; if (MEM_WRITE !== 1'b0 || count !== 3'd2) begin errors++;
      $display("FAIL order_block: write=%b count=%0d, want 0 2", MEM_WRITE, count); end
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h300;
    step();
    cdb_valid = 1'b0;
    n = 0;
    while (!MEM_WRITE && n < 20) begin step(); n++; end
    checks++; if (MEM_WRITE !== 1'b1 || MEM_ADDR2 !== 32'h310 || MEM_DIN2 !== 32'hA) begin errors++;
      $display("FAIL order_A: write=%b addr=%h din=%h, want 1 310 a", MEM_WRITE, MEM_ADDR2, MEM_DIN2); end
    mem_resp_valid = 1'b1;
    #1;
    checks++; if (done !== 1'b1 || done_tag !== 5'd3) begin errors++;
      $display("FAIL order_doneA: done=%b tag=%0d, want 1 3", done, done_tag); end
    step();
    mem_resp_valid = 1'b0;
    n = 0;
    while (!MEM_WRITE && n < 20) begin step(); n++; end
    checks++; if (MEM_WRITE !== 1'b1 || MEM_ADDR2 !== 32'h204 || MEM_DIN2 !== 32'hB) begin errors++;
      $display("FAIL order_B: write=%b addr=%h din=%h, want 1 204 b", MEM_WRITE, MEM_ADDR2, MEM_DIN2); end
    mem_resp_valid = 1'b1;
    #1;
    checks++; if (done !== 1'b1 || done_tag !== 5'd4) begin errors++;
      $display("FAIL order_doneB: done=%b tag=%0d, want 1 4", done, done_tag); end
    step();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_full_wrap;
    int n;
    for (int k = 0; k < 4; k++)
      disp(32'h1000 + 32'(k * 16), 32'h0, 32'(k), 1, 1, 0, 0, 5'(8 + k), 3'b110);
    checks++; if (count !== 3'd4 || disp_ready !== 1'b0) begin errors++;
      $display("FAIL full: count=%0d ready=%b, want 4 0", count, disp_ready); end
    disp(32'hBAD0, 32'h0, 32'h0, 1, 1, 0, 0, 5'd30, 3'b010);
    checks++; if (count !== 3'd4) begin errors++;
      $display("FAIL full_drop: count=%0d, want 4", count); end
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!MEM_WRITE && n < 20) begin step(); n++; end
      checks++; if (MEM_WRITE !== 1'b1 || MEM_ADDR2 !== 32'h1000 + 32'(k * 16) || MEM_SIZE !== 2'd2 || MEM_SIGN !== 1'b1) begin errors++;
        $display("FAIL wrap_addr%0d: write=%b addr=%h size=%0d sign=%b, want 1 %h 2 1", k, MEM_WRITE, MEM_ADDR2, MEM_SIZE, MEM_SIGN, 32'h1000 + 32'(k * 16)); end
      mem_resp_valid = 1'b1;
      #1;
      checks++; if (done !== 1'b1 || done_tag !== 5'(8 + k)) begin errors++;
        $display("FAIL wrap_tag%0d: done=%b tag=%0d, want 1 %0d", k, done, done_tag, 8 + k); end
      step();
      mem_resp_valid = 1'b0;
      if (k < 2) disp(32'h1000 + 32'((k + 4) * 16), 32'h0, 32'(k + 4), 1, 1, 0, 0, 5'(12 + k), 3'b110);
    end
    checks++; if (count !== 3'd0) begin errors++;
      $display("FAIL wrap_empty: count=%0d, want 0", count); end
  endtask

  task automatic test_flush;
    int extra = 0;
    disp(32'h2000, 32'h0, 32'h1, 1, 1, 0, 0, 5'd20, 3'b010);
    disp(32'h2010, 32'h0, 32'h2, 1, 1, 0, 0, 5'd21, 3'b010);
    disp(32'h2020, 32'h0, 32'h3, 1, 1, 0, 0, 5'd22, 3'b010);
    checks++; if (count !== 3'd3 || MEM_WRITE !== 1'b1) begin errors++;
      $display("FAIL flush_pre: count=%0d write=%b, want 3 1", count, MEM_WRITE); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (count !== 3'd1 || MEM_WRITE !== 1'b1 || MEM_ADDR2 !== 32'h2000) begin errors++;
      $display("FAIL flush_cnt: count=%0d write=%b addr=%h, want 1 1 2000", count, MEM_WRITE, MEM_ADDR2); end
    mem_resp_valid = 1'b1;
    #1;
    checks++; if (done !== 1'b1 || done_tag !== 5'd20) begin errors++;
      $display("FAIL flush_done: done=%b tag=%0d, want 1 20", done, done_tag); end
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (MEM_WRITE !== 1'b0) extra++;
    end
    checks++; if (extra != 0 || count !== 3'd0) begin errors++;
      $display("FAIL flush_quiet: write_cycles=%0d count=%0d, want 0 0", extra, count); end
  endtask

  task automatic test_async_reset;
    int n;
    disp(32'h3000, 32'h4, 32'h77, 1, 1, 0, 0, 5'd11, 3'b001);
    n = 0;
    while (!MEM_WRITE && n < 20) begin step(); n++; end
    checks++; if (MEM_WRITE !== 1'b1) begin errors++;
      $display("FAIL areset_pre: write=%b, want 1", MEM_WRITE); end
    #1;
    RST_N = 1'b0;
    #1;
    checks++; if (MEM_WRITE !== 1'b0 || MEM_ADDR2 !== 32'h0 || MEM_DIN2 !== 32'h0 || MEM_SIZE !== 2'd0 || count !== 3'd0 || disp_ready !== 1'b1) begin errors++;
      $display("FAIL areset_out: write=%b addr=%h din=%h size=%0d count=%0d ready=%b, want 0 0 0 0 0 1", MEM_WRITE, MEM_ADDR2, MEM_DIN2, MEM_SIZE, count, disp_ready); end
    step();
    RST_N = 1'b1;
    step();
    mem_resp_valid = 1'b1;
    #1;
    checks++; if (done !== 1'b0 || done_tag !== 5'd0) begin errors++;
      $display("FAIL areset_nodone: done=%b tag=%0d, want 0 0", done, done_tag); end
    step();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    disp_valid = 0; disp_V1 = 0; disp_V2 = 0; disp_V3 = 0;
    disp_V1_valid = 0; disp_V3_valid = 0;
    disp_V1_tag = 0; disp_V3_tag = 0; disp_rd_tag = 0; disp_mem_type = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    flush = 0; mem_resp_valid = 0;
    test_reset();
    test_ready_store();
    test_cdb_wakeup();
    test_ordering();
    test_full_wrap();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
